// File: rtl/pwm_link_pkg.sv
// Shared definitions for both ends of the position-over-PWM link.
// The generator and the decoder import the same defaults so the frame encoding agrees.
package pwm_link_pkg;

    localparam int unsigned PWM_POS_W      = 10;
    localparam int unsigned PWM_OFFSET     = 16;
    localparam int unsigned PWM_PERIOD_NOM = 2048;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HIGH = 2'd1,
        ST_LOW  = 2'd2
    } pwm_state_t;

endpackage

// File: rtl/pwm_input_conditioner.sv
// PWM input conditioning: 2-FF synchronizer, optional glitch filter, registered edge detect.
// Optional feature macro: PWM_GLITCH_FILTER_EN (level accepted after FILT_LEN equal samples).
module pwm_input_conditioner #(
    parameter int unsigned FILT_LEN = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic pwm,
    output logic pwm_s,
    output logic rise,
    output logic fall
);

    logic r_sync1;
    logic r_sync2;
    logic r_level_d;
    logic r_rise;
    logic r_fall;
    logic w_level;

    // Two-stage synchronizer for the asynchronous pwm pin.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= pwm;
            r_sync2 <= r_sync1;
        end
    end

`ifdef PWM_GLITCH_FILTER_EN
    localparam int unsigned FC_W = $clog2(FILT_LEN + 1);

    logic [FC_W-1:0] r_filt_cnt;
    logic            r_filt;

    // Accept a new level only after it has been seen for FILT_LEN consecutive cycles.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_filt_cnt <= '0;
            r_filt     <= 1'b0;
        end else if (r_sync2 == r_filt) begin
            r_filt_cnt <= '0;
        end else if (r_filt_cnt == FC_W'(FILT_LEN - 1)) begin
            r_filt_cnt <= '0;
            r_filt     <= r_sync2;
        end else begin
            r_filt_cnt <= r_filt_cnt + 1'b1;
        end
    end

    assign w_level = r_filt;
`else
    assign w_level = r_sync2;
`endif

    // Registered edge detect on the conditioned level.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_level_d <= 1'b0;
            r_rise    <= 1'b0;
            r_fall    <= 1'b0;
        end else begin
            r_level_d <= w_level;
            r_rise    <= w_level & ~r_level_d;
            r_fall    <= ~w_level & r_level_d;
        end
    end

    assign pwm_s = w_level;
    assign rise  = r_rise;
    assign fall  = r_fall;

endmodule

// File: rtl/pwm_position_decoder.sv
// Position-over-PWM decoder: measures high time H and period P of each frame,
// validates the period window, clamps out-of-range high times and detects a dead line.
// Optional feature macro: PWM_GLITCH_FILTER_EN (handled inside pwm_input_conditioner).
//
// state   | meaning
// IDLE    | no frame in progress; waiting for a rising edge
// HIGH    | high phase; counting high time and period
// LOW     | low phase; counting period, next rising edge closes the frame
module pwm_position_decoder
    import pwm_link_pkg::*;
#(
    parameter int unsigned POS_W      = PWM_POS_W,
    parameter int unsigned CNT_W      = 12,
    parameter int unsigned OFFSET     = PWM_OFFSET,
    parameter int unsigned PERIOD_NOM = PWM_PERIOD_NOM,
    parameter int unsigned PERIOD_TOL = 32,
    parameter int unsigned TIMEOUT    = 4095,
    parameter int unsigned FILT_LEN   = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             pwm,
    output logic [POS_W-1:0] Position,
    output logic             pos_valid,
    output logic             pos_strobe,
    output logic             err_period,
    output logic             err_range,
    output logic             err_timeout,
    output logic             stuck_level
);

    localparam logic [CNT_W-1:0] C_OFFSET  = CNT_W'(OFFSET);
    localparam logic [CNT_W-1:0] C_H_MAX   = CNT_W'(OFFSET + (1 << POS_W) - 1);
    localparam logic [CNT_W-1:0] C_P_MIN   = CNT_W'(PERIOD_NOM - PERIOD_TOL);
    localparam logic [CNT_W-1:0] C_P_MAX   = CNT_W'(PERIOD_NOM + PERIOD_TOL);
    localparam logic [CNT_W-1:0] C_TMO     = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] C_TMO_M1  = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] C_SAT     = '1;
    localparam logic [POS_W-1:0] C_POS_MAX = '1;

    logic w_pwm_s;
    logic w_rise;
    logic w_fall;
    logic w_edge;

    pwm_state_t       r_state;
    pwm_state_t       w_state_next;
    logic             w_start;
    logic             w_latch_h;
    logic             w_eval;
    logic             w_tmo_hit;
    logic             w_per_ok;
    logic [POS_W-1:0] w_pos_raw;

    logic [CNT_W-1:0] r_high_cnt;
    logic [CNT_W-1:0] r_per_cnt;
    logic [CNT_W-1:0] r_h;
    logic [CNT_W-1:0] r_sil;
    logic [POS_W-1:0] r_pos;
    logic             r_pos_valid;
    logic             r_strobe;
    logic             r_err_period;
    logic             r_err_range;
    logic             r_err_timeout;
    logic             r_stuck;

    pwm_input_conditioner #(
        .FILT_LEN (FILT_LEN)
    ) u_cond (
        .clk   (clk),
        .reset (reset),
        .pwm   (pwm),
        .pwm_s (w_pwm_s),
        .rise  (w_rise),
        .fall  (w_fall)
    );

    assign w_edge    = w_rise | w_fall;
    // An edge in the same cycle wins over the timeout because it clears the silence count.
    assign w_tmo_hit = !w_edge && (r_sil == C_TMO_M1);
    assign w_per_ok  = (r_per_cnt >= C_P_MIN) && (r_per_cnt <= C_P_MAX);
    assign w_pos_raw = POS_W'(r_h - C_OFFSET);

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and control strobes; wrong-polarity edges leave the state alone.
    always_comb begin
        w_state_next = r_state;
        w_start      = 1'b0;
        w_latch_h    = 1'b0;
        w_eval       = 1'b0;
        case (r_state)
            ST_IDLE: if (w_rise) begin
                w_start      = 1'b1;
                w_state_next = ST_HIGH;
            end
            ST_HIGH: if (w_fall) begin
                w_latch_h    = 1'b1;
                w_state_next = ST_LOW;
            end
            ST_LOW: if (w_rise) begin
                w_eval       = 1'b1;
                w_start      = 1'b1;
                w_state_next = ST_HIGH;
            end
            default: w_state_next = ST_IDLE;
        endcase
        if (w_tmo_hit) begin
            w_state_next = ST_IDLE;
        end
    end

    // Frame counters. The edge cycle is the first cycle of the new frame, so the
    // counters restart at 1 and H and P come out directly in clk cycles.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_high_cnt <= '0;
            r_per_cnt  <= '0;
            r_h        <= '0;
        end else begin
            if (w_start) begin
                r_high_cnt <= CNT_W'(1);
                r_per_cnt  <= CNT_W'(1);
            end else begin
                if (r_state == ST_HIGH && r_high_cnt != C_SAT) begin
                    r_high_cnt <= r_high_cnt + 1'b1;
                end
                if ((r_state == ST_HIGH || r_state == ST_LOW) && r_per_cnt != C_SAT) begin
                    r_per_cnt <= r_per_cnt + 1'b1;
                end
            end
            if (w_latch_h) begin
                r_h <= r_high_cnt;
            end
        end
    end

    // Silence counter: cleared by any edge, parks at TIMEOUT so the timeout fires once.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sil <= '0;
        end else if (w_edge) begin
            r_sil <= '0;
        end else if (r_sil != C_TMO) begin
            r_sil <= r_sil + 1'b1;
        end
    end

    // Frame evaluation and timeout reporting.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pos         <= '0;
            r_pos_valid   <= 1'b0;
            r_strobe      <= 1'b0;
            r_err_period  <= 1'b0;
            r_err_range   <= 1'b0;
            r_err_timeout <= 1'b0;
            r_stuck       <= 1'b0;
        end else begin
            r_strobe     <= 1'b0;
            r_err_period <= 1'b0;
            r_err_range  <= 1'b0;
            if (w_eval) begin
                if (!w_per_ok) begin
                    r_err_period <= 1'b1;
                end else begin
                    r_strobe      <= 1'b1;
                    r_pos_valid   <= 1'b1;
                    r_err_timeout <= 1'b0;
                    if (r_h < C_OFFSET) begin
                        r_pos       <= '0;
                        r_err_range <= 1'b1;
                    end else if (r_h > C_H_MAX) begin
                        r_pos       <= C_POS_MAX;
                        r_err_range <= 1'b1;
                    end else begin
                        r_pos <= w_pos_raw;
                    end
                end
            end else if (w_tmo_hit) begin
                r_err_timeout <= 1'b1;
                r_pos_valid   <= 1'b0;
                r_stuck       <= w_pwm_s;
            end
        end
    end

    assign Position    = r_pos;
    assign pos_valid   = r_pos_valid;
    assign pos_strobe  = r_strobe;
    assign err_period  = r_err_period;
    assign err_range   = r_err_range;
    assign err_timeout = r_err_timeout;
    assign stuck_level = r_stuck;

endmodule

// File: tb/tb_pwm_position_decoder.sv
// Scoreboard bench for pwm_position_decoder: stimulus pushes hand-computed
// expectations, a negedge monitor pops one per reported DUT event.
// Honours PWM_GLITCH_FILTER_EN (adds a glitch frame, shifts timeout latency).
`timescale 1ns/1ps
module tb_pwm_position_decoder;

`ifdef PWM_GLITCH_FILTER_EN
    localparam int FILT_DLY = 3;
`else
    localparam int FILT_DLY = 0;
`endif
    // Pin change at a negedge -> err_timeout seen 4099 posedges later (+ filter delay).
    localparam int TMO_LAT = 4099 + FILT_DLY;

    localparam int K_STROBE = 0;
    localparam int K_PERIOD = 1;
    localparam int K_TMO    = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       pwm = 1'b0;
    logic [9:0] Position;
    logic       pos_valid;
    logic       pos_strobe;
    logic       err_period;
    logic       err_range;
    logic       err_timeout;
    logic       stuck_level;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    typedef struct {
        int kind;
        int pos;
        bit rng;
        bit valid;
        bit tmo;
        bit stuck;
        int at;
    } exp_t;

    exp_t sb[$];

    int e_pos = 0;
    bit e_valid = 1'b0;
    bit e_tmo = 1'b0;

    pwm_position_decoder dut (
        .clk         (clk),
        .reset       (reset),
        .pwm         (pwm),
        .Position    (Position),
        .pos_valid   (pos_valid),
        .pos_strobe  (pos_strobe),
        .err_period  (err_period),
        .err_range   (err_range),
        .err_timeout (err_timeout),
        .stuck_level (stuck_level)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, want, cyc);
        end
    endtask

    // Push the expected event and advance the bench's own model of the held outputs.
    task automatic push_exp(input int kind, input int pos, input bit rng, input int at);
        exp_t e;
        if (kind == K_STROBE) begin
            e_pos   = pos;
            e_valid = 1'b1;
            e_tmo   = 1'b0;
        end else if (kind == K_TMO) begin
            e_valid = 1'b0;
            e_tmo   = 1'b1;
        end
        e.kind  = kind;
        e.pos   = e_pos;
        e.rng   = rng;
        e.valid = e_valid;
        e.tmo   = e_tmo;
        e.stuck = 1'b1;
        e.at    = at;
        sb.push_back(e);
    endtask

    // One frame; its result is reported after the rising edge that starts the next one.
    task automatic frame(input int h, input int p, input int kind, input int pos, input bit rng);
        push_exp(kind, pos, rng, 0);
        pwm = 1'b1;
        repeat (h) @(negedge clk);
        pwm = 1'b0;
        repeat (p - h) @(negedge clk);
    endtask

`ifdef PWM_GLITCH_FILTER_EN
    task automatic frame_glitch(input int h, input int p, input int pos);
        push_exp(K_STROBE, pos, 1'b0, 0);
        pwm = 1'b1;
        repeat (h / 2) @(negedge clk);
        pwm = 1'b0;
        repeat (2) @(negedge clk);
        pwm = 1'b1;
        repeat (h - h / 2 - 2) @(negedge clk);
        pwm = 1'b0;
        repeat (p - h) @(negedge clk);
    endtask
`endif

    task automatic chk_all_zero(input string tag);
        chk({tag, "_Position"}, Position, 0);
        chk({tag, "_pos_valid"}, pos_valid, 0);
        chk({tag, "_pos_strobe"}, pos_strobe, 0);
        chk({tag, "_err_period"}, err_period, 0);
        chk({tag, "_err_range"}, err_range, 0);
        chk({tag, "_err_timeout"}, err_timeout, 0);
        chk({tag, "_stuck_level"}, stuck_level, 0);
    endtask

    // Monitor: every strobe, period error or timeout onset consumes one expectation.
    logic prev_tmo = 1'b0;
    always @(negedge clk) begin : monitor
        int   kind;
        exp_t e;
        if (reset) begin
            if (pos_strobe || err_period || (err_timeout && !prev_tmo)) begin
                kind = pos_strobe ? K_STROBE : (err_period ? K_PERIOD : K_TMO);
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_event: kind %0d Position %0d at cycle %0d, none expected",
                             kind, Position, cyc);
                end else begin
                    e = sb.pop_front();
                    chk("event_kind", kind, e.kind);
                    chk("Position", Position, e.pos);
                    chk("err_range", err_range, e.rng);
                    chk("pos_valid", pos_valid, e.valid);
                    chk("err_timeout", err_timeout, e.tmo);
                    if (e.kind == K_TMO) chk("stuck_level", stuck_level, e.stuck);
                    if (e.at != 0) chk("timeout_cycle", cyc, e.at);
                end
            end else if (err_range) begin
                checks++;
                failures++;
                $display("FAIL err_range_without_strobe: err_range 1 expected 0 at cycle %0d", cyc);
            end
        end
        prev_tmo = err_timeout;
    end

    initial begin : stim
        int t_drive;
        reset = 1'b0;
        pwm   = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk_all_zero("reset");
        @(negedge clk);
        reset = 1'b1;
        repeat (4) @(negedge clk);

        // Generator-like frames, then exact boundaries.
        frame(17,   2048, K_STROBE, 1,    1'b0);
        frame(1038, 2048, K_STROBE, 1022, 1'b0);
        frame(16,   2048, K_STROBE, 0,    1'b0);
        frame(1039, 2048, K_STROBE, 1023, 1'b0);
        // Out-of-range high times clamp.
        frame(12,   2048, K_STROBE, 0,    1'b1);
        frame(1100, 2048, K_STROBE, 1023, 1'b1);
        // Period window edges.
        frame(516,  2015, K_PERIOD, 0,    1'b0);
        frame(516,  2081, K_PERIOD, 0,    1'b0);
        frame(516,  2016, K_STROBE, 500,  1'b0);
`ifdef PWM_GLITCH_FILTER_EN
        frame_glitch(416, 2048, 400);
`endif
        frame(266,  2080, K_STROBE, 250,  1'b0);

        // Dead line held high.
        t_drive = cyc;
        pwm = 1'b1;
        push_exp(K_TMO, 0, 1'b0, t_drive + TMO_LAT);
        repeat (5000) @(negedge clk);
        pwm = 1'b0;
        repeat (100) @(negedge clk);
        frame(116,  2048, K_STROBE, 100,  1'b0);

        // Reset in the middle of a high phase.
        pwm = 1'b1;
        repeat (50) @(negedge clk);
        reset = 1'b0;
        #1;
        chk_all_zero("midframe_reset");
        pwm = 1'b0;
        repeat (5) @(negedge clk);
        reset = 1'b1;
        e_pos   = 0;
        e_valid = 1'b0;
        e_tmo   = 1'b0;
        repeat (3) @(negedge clk);
        frame(216,  2048, K_STROBE, 200,  1'b0);
        frame(316,  2048, K_STROBE, 300,  1'b0);
        pwm = 1'b1;

        for (int i = 0; i < 200 && sb.size() != 0; i++) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d expected events still pending, required 0", sb.size());
        end
        repeat (5) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
